// File: rtl/split_port_tx.sv
// Word-to-half-word serialiser: each accepted word leaves as two beats on a
// valid/ready link, with a holding register so words can follow back to back.
module split_port_tx #(
  parameter int WIDTH    = 8,
  parameter int HI_FIRST = 1,
  parameter int CNT_W    = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [WIDTH/2-1:0] out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_hi,
  output logic               out_last,
  output logic [CNT_W-1:0]   words_sent
);

  localparam int HW = WIDTH / 2;
  localparam logic HI_FIRST_BIT = (HI_FIRST != 0);

  typedef enum logic [1:0] {IDLE, FIRST, SECOND} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] hold_reg, hold_next;
  logic [CNT_W-1:0] cnt_reg;
  logic             in_xfer, out_xfer;
  logic [HW-1:0]    hi_half, lo_half;

  assign hi_half    = hold_reg[WIDTH-1:HW];
  assign lo_half    = hold_reg[HW-1:0];
  assign in_xfer    = in_valid & in_ready;
  assign out_xfer   = out_valid & out_ready;
  assign words_sent = cnt_reg;

  // State, holding register and sent-word counter; reset wins over any transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      hold_reg  <= '0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      hold_reg  <= hold_next;
      if (state_reg == SECOND && out_xfer)
        cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

  always_comb begin
    state_next = state_reg;
    hold_next  = hold_reg;
    case (state_reg)
      IDLE: begin
        if (in_xfer) begin
          hold_next  = in_data;
          state_next = FIRST;
        end
      end
      FIRST: begin
        if (out_xfer)
          state_next = SECOND;
      end
      SECOND: begin
        // A word can be loaded on the same edge the last beat leaves.
        if (in_xfer) begin
          hold_next  = in_data;
          state_next = FIRST;
        end else if (out_xfer) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // in_ready depends only on state and out_ready, never on in_valid.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    out_hi    = 1'b0;
    out_last  = 1'b0;
    case (state_reg)
      IDLE: in_ready = 1'b1;
      FIRST: begin
        out_valid = 1'b1;
        out_data  = HI_FIRST_BIT ? hi_half : lo_half;
        out_hi    = HI_FIRST_BIT;
      end
      SECOND: begin
        in_ready  = out_ready;
        out_valid = 1'b1;
        out_data  = HI_FIRST_BIT ? lo_half : hi_half;
        out_hi    = ~HI_FIRST_BIT;
        out_last  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
